// File: rtl/rails_stack_ctrl_if.sv
// rails_stack_ctrl_if
// Bundles the pattern input stream, the stack command/status lines and the
// result strobe of rails_stack_ctrl.
//   slave  : view of the sequencer (consumes data, drives stack commands)
//   master : view of the environment (drives data, owns the stack)
// Signals:
//   data/data_vld/data_rdy      pattern stream handshake
//   stk_push/stk_wdata/stk_pop/stk_clr   commands to the stack block
//   stk_top/stk_empty/stk_full  registered status from the stack block
//   valid/result/busy           result strobe, held result, activity flag
interface rails_stack_ctrl_if #(
    parameter int DW = 4
);
    logic [DW-1:0] data;
    logic          data_vld;
    logic          data_rdy;
    logic          stk_push;
    logic [DW-1:0] stk_wdata;
    logic          stk_pop;
    logic          stk_clr;
    logic [DW-1:0] stk_top;
    logic          stk_empty;
    logic          stk_full;
    logic          valid;
    logic          result;
    logic          busy;

    modport slave (
        input  data, data_vld, stk_top, stk_empty, stk_full,
        output data_rdy, stk_push, stk_wdata, stk_pop, stk_clr,
               valid, result, busy
    );

    modport master (
        output data, data_vld, stk_top, stk_empty, stk_full,
        input  data_rdy, stk_push, stk_wdata, stk_pop, stk_clr,
               valid, result, busy
    );
endinterface

// File: rtl/rails_stack_ctrl.sv
// rails_stack_ctrl
// Sequencer for the rails stack-permutation check. Loads a count word N and
// N car numbers, then walks the outgoing order against an external LIFO
// stack using one-cycle push/pop/clear commands, and reports pass/fail with
// a one-cycle valid strobe (result held until the next strobe).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    rails_stack_ctrl_if.slave (stream, stack commands/status, result)
// Optional build macro RAILS_STAT_EN adds 8-bit saturating pass_cnt and
// fail_cnt outputs counting completed patterns by result.
module rails_stack_ctrl #(
    parameter int DW   = 4,
    parameter int MAXN = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    rails_stack_ctrl_if.slave    bus
`ifdef RAILS_STAT_EN
    ,
    output logic [7:0]           pass_cnt,
    output logic [7:0]           fail_cnt
`endif
);

    localparam int AW = (MAXN > 1) ? $clog2(MAXN) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CMP  = 3'd2,
        S_PUSH = 3'd3,
        S_POP  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [DW-1:0] n_r;
    logic [DW-1:0] ptr_r;
    logic [DW:0]   idx_r;      // one bit wider so idx == MAXN is representable
    logic [DW:0]   next_r;     // one bit wider so next = MAXN+1 does not wrap
    logic [DW-1:0] pat_r [MAXN];
    logic          result_r;

    logic          data_rdy_s;
    logic          accept_s;
    logic          hdr_ok_s;
    logic          set_res_s;
    logic          res_val_s;
    logic [DW-1:0] t_s;

    assign data_rdy_s = (state_r == S_IDLE) || (state_r == S_LOAD);
    assign accept_s   = bus.data_vld && data_rdy_s;
    assign hdr_ok_s   = (bus.data != {DW{1'b0}}) && (bus.data <= DW'(MAXN));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decision and result capture request.
    always_comb begin
        state_nxt_s = state_r;
        set_res_s   = 1'b0;
        res_val_s   = 1'b0;
        // Car at the head of the outgoing order; idx may equal N (end marker).
        if (idx_r < (DW+1)'(MAXN)) begin
            t_s = pat_r[idx_r[AW-1:0]];
        end else begin
            t_s = {DW{1'b0}};
        end
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (hdr_ok_s) begin
                        state_nxt_s = S_LOAD;
                    end else begin
                        state_nxt_s = S_DONE;
                        set_res_s   = 1'b1;
                        res_val_s   = 1'b0;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (accept_s && (ptr_r == n_r - DW'(1))) begin
                    state_nxt_s = S_CMP;
                end else begin
                    state_nxt_s = S_LOAD;
                end
            end
            S_CMP: begin
                if (idx_r == {1'b0, n_r}) begin
                    state_nxt_s = S_DONE;
                    set_res_s   = 1'b1;
                    res_val_s   = 1'b1;
                end else if (!bus.stk_empty && (bus.stk_top == t_s)) begin
                    state_nxt_s = S_POP;
                end else if ((t_s == {DW{1'b0}}) || (t_s > n_r)) begin
                    state_nxt_s = S_DONE;
                    set_res_s   = 1'b1;
                end else if (next_r <= {1'b0, t_s}) begin
                    // A full stack cannot take the push that is needed.
                    if (bus.stk_full) begin
                        state_nxt_s = S_DONE;
                        set_res_s   = 1'b1;
                    end else begin
                        state_nxt_s = S_PUSH;
                    end
                end else begin
                    // Wanted car is buried below the top: unreachable order.
                    state_nxt_s = S_DONE;
                    set_res_s   = 1'b1;
                end
            end
            S_PUSH:  state_nxt_s = S_CMP;
            S_POP:   state_nxt_s = S_CMP;
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Pattern buffer, counters and held result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_r      <= {DW{1'b0}};
            ptr_r    <= {DW{1'b0}};
            idx_r    <= {(DW+1){1'b0}};
            next_r   <= {(DW+1){1'b0}};
            result_r <= 1'b0;
            for (int i = 0; i < MAXN; i++) begin
                pat_r[i] <= {DW{1'b0}};
            end
        end else begin
            if ((state_r == S_IDLE) && accept_s) begin
                n_r    <= bus.data;
                ptr_r  <= {DW{1'b0}};
                idx_r  <= {(DW+1){1'b0}};
                next_r <= (DW+1)'(1);
            end
            if ((state_r == S_LOAD) && accept_s) begin
                pat_r[ptr_r[AW-1:0]] <= bus.data;
                ptr_r                <= ptr_r + DW'(1);
            end
            if (state_r == S_PUSH) begin
                next_r <= next_r + (DW+1)'(1);
            end
            if (state_r == S_POP) begin
                idx_r <= idx_r + (DW+1)'(1);
            end
            if (set_res_s) begin
                result_r <= res_val_s;
            end
        end
    end

    // Outputs are pure decodes of the state register and held registers.
    assign bus.data_rdy  = data_rdy_s;
    assign bus.stk_push  = (state_r == S_PUSH);
    assign bus.stk_wdata = (state_r == S_PUSH) ? next_r[DW-1:0] : {DW{1'b0}};
    assign bus.stk_pop   = (state_r == S_POP);
    assign bus.stk_clr   = (state_r == S_DONE);
    assign bus.valid     = (state_r == S_DONE);
    assign bus.result    = result_r;
    assign bus.busy      = (state_r != S_IDLE);

`ifdef RAILS_STAT_EN
    // Saturating pass/fail statistics, bumped once per completed pattern.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pass_cnt <= 8'd0;
            fail_cnt <= 8'd0;
        end else if (state_r == S_DONE) begin
            if (result_r) begin
                if (pass_cnt != 8'hFF) begin
                    pass_cnt <= pass_cnt + 8'd1;
                end
            end else begin
                if (fail_cnt != 8'hFF) begin
                    fail_cnt <= fail_cnt + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rails_stack_ctrl.sv
module tb_rails_stack_ctrl;
    localparam int DW   = 4;
    localparam int MAXN = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rails_stack_ctrl_if #(.DW(DW)) bus ();

`ifdef RAILS_STAT_EN
    logic [7:0] pass_cnt;
    logic [7:0] fail_cnt;
`endif

    rails_stack_ctrl #(.DW(DW), .MAXN(MAXN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef RAILS_STAT_EN
        ,
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt)
`endif
    );

    // Behavioural stack: registered top, depth 10, optional forced full.
    logic [DW-1:0] smem [32];
    logic [4:0]    sp;
    logic          force_full;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp          <= 5'd0;
            bus.stk_top <= '0;
        end else if (bus.stk_clr) begin
            sp          <= 5'd0;
            bus.stk_top <= '0;
        end else if (bus.stk_push && sp < 5'd10) begin
            smem[sp]    <= bus.stk_wdata;
            sp          <= sp + 5'd1;
            bus.stk_top <= bus.stk_wdata;
        end else if (bus.stk_pop && sp > 5'd0) begin
            sp          <= sp - 5'd1;
            bus.stk_top <= (sp >= 5'd2) ? smem[sp - 5'd2] : '0;
        end
    end

    assign bus.stk_empty = (sp == 5'd0);
    assign bus.stk_full  = (sp >= 5'd10) || force_full;

    // Cycle counter and output monitor.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            push_cnt, pop_cnt, clr_cnt, valid_cnt, valid_cyc, push_full_cnt;
    logic          valid_res, valid_clr, valid_rdy;
    logic [DW-1:0] wlog [8];
    int            last_cyc;
    int            checks = 0;
    int            errors = 0;

    always @(negedge clk) begin
        if (bus.stk_push) begin
            if (push_cnt < 8) wlog[push_cnt] = bus.stk_wdata;
            push_cnt++;
            if (bus.stk_full) push_full_cnt++;
        end
        if (bus.stk_pop) pop_cnt++;
        if (bus.stk_clr) clr_cnt++;
        if (bus.valid) begin
            valid_cnt++;
            valid_cyc = cyc;
            valid_res = bus.result;
            valid_clr = bus.stk_clr;
            valid_rdy = bus.data_rdy;
        end
    end

    task automatic clear_mon();
        @(posedge clk);
        #1;
        push_cnt = 0; pop_cnt = 0; clr_cnt = 0; valid_cnt = 0;
        valid_cyc = 0; push_full_cnt = 0;
        valid_res = 1'b0; valid_clr = 1'b0; valid_rdy = 1'b0;
        for (int i = 0; i < 8; i++) wlog[i] = '0;
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        @(negedge clk);
        bus.data     = w;
        bus.data_vld = 1'b1;
        last_cyc     = cyc;
        @(posedge clk);
    endtask

    task automatic idle_in();
        @(negedge clk);
        bus.data_vld = 1'b0;
        bus.data     = '0;
    endtask

    // cars: first car in bits [3:0], second in [7:4], ...
    task automatic send_pattern(input logic [DW-1:0] n, input logic [39:0] cars, input bit gap);
        send_word(n);
        for (int i = 0; i < int'(n); i++) begin
            send_word(cars[4*i +: 4]);
            if (gap && i == 0) begin
                @(negedge clk);
                bus.data_vld = 1'b0;
                @(posedge clk);
            end
        end
        idle_in();
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 100 && valid_cnt == 0; i++) @(negedge clk);
        checks++;
        if (valid_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout: valid count %0d, need 1", name, valid_cnt);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (valid_cnt !== 1) begin
            errors++;
            $display("FAIL %s_single_valid: got %0d pulses, need 1", name, valid_cnt);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.data_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s_back_idle: busy %b data_rdy %b, need 0 1", name, bus.busy, bus.data_rdy);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bus.data_rdy !== 1'b1 || bus.stk_push !== 1'b0 || bus.stk_pop !== 1'b0 ||
            bus.stk_clr !== 1'b0 || bus.valid !== 1'b0 || bus.result !== 1'b0 ||
            bus.busy !== 1'b0 || bus.stk_wdata !== 4'd0) begin
            errors++;
            $display("FAIL %s: rdy %b push %b pop %b clr %b valid %b result %b busy %b wdata %0d, need 1 0 0 0 0 0 0 0",
                     name, bus.data_rdy, bus.stk_push, bus.stk_pop, bus.stk_clr,
                     bus.valid, bus.result, bus.busy, bus.stk_wdata);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_release");
    endtask

    task automatic test_identity();
        clear_mon();
        send_pattern(4'd5, 40'h0000054321, 1'b0);
        wait_valid("identity");
        checks++;
        if (valid_cyc - last_cyc !== 22) begin
            errors++;
            $display("FAIL identity_latency: got %0d, need 22", valid_cyc - last_cyc);
        end
        checks++;
        if (valid_res !== 1'b1 || valid_clr !== 1'b1 || clr_cnt !== 1) begin
            errors++;
            $display("FAIL identity_result: result %b clr %b clr_cnt %0d, need 1 1 1", valid_res, valid_clr, clr_cnt);
        end
        checks++;
        if (push_cnt !== 5 || pop_cnt !== 5) begin
            errors++;
            $display("FAIL identity_ops: push %0d pop %0d, need 5 5", push_cnt, pop_cnt);
        end
    endtask

    task automatic test_unreachable();
        clear_mon();
        send_pattern(4'd5, 40'h0000032145, 1'b0);
        wait_valid("unreach");
        checks++;
        if (valid_res !== 1'b0 || valid_cyc - last_cyc !== 16) begin
            errors++;
            $display("FAIL unreach_result: result %b latency %0d, need 0 16", valid_res, valid_cyc - last_cyc);
        end
        checks++;
        if (push_cnt !== 5 || pop_cnt !== 2 || wlog[4] !== 4'd5) begin
            errors++;
            $display("FAIL unreach_ops: push %0d pop %0d last wdata %0d, need 5 2 5", push_cnt, pop_cnt, wlog[4]);
        end
    endtask

    task automatic test_bad_header();
        logic [DW-1:0] hdrs [2];
        hdrs[0] = 4'd0;
        hdrs[1] = 4'd11;
        for (int h = 0; h < 2; h++) begin
            clear_mon();
            send_word(hdrs[h]);
            idle_in();
            wait_valid("bad_header");
            checks++;
            if (valid_res !== 1'b0 || valid_cyc - last_cyc !== 1 || valid_rdy !== 1'b0) begin
                errors++;
                $display("FAIL bad_header_%0d: result %b latency %0d rdy %b, need 0 1 0",
                         hdrs[h], valid_res, valid_cyc - last_cyc, valid_rdy);
            end
            checks++;
            if (push_cnt !== 0) begin
                errors++;
                $display("FAIL bad_header_push_%0d: got %0d pushes, need 0", hdrs[h], push_cnt);
            end
        end
    endtask

    task automatic test_full();
        clear_mon();
        force_full = 1'b1;
        send_pattern(4'd2, 40'h0000000012, 1'b0);
        wait_valid("full");
        force_full = 1'b0;
        checks++;
        if (valid_res !== 1'b0 || push_cnt !== 0 || push_full_cnt !== 0) begin
            errors++;
            $display("FAIL full_stack: result %b push %0d push_on_full %0d, need 0 0 0", valid_res, push_cnt, push_full_cnt);
        end
        checks++;
        if (valid_cyc - last_cyc !== 2) begin
            errors++;
            $display("FAIL full_latency: got %0d, need 2", valid_cyc - last_cyc);
        end
    endtask

    task automatic test_reverse(input bit gap);
        clear_mon();
        send_pattern(4'd3, 40'h0000000123, gap);
        wait_valid("reverse");
        checks++;
        if (valid_res !== 1'b1 || valid_cyc - last_cyc !== 14) begin
            errors++;
            $display("FAIL reverse_result: result %b latency %0d, need 1 14", valid_res, valid_cyc - last_cyc);
        end
        checks++;
        if (wlog[0] !== 4'd1 || wlog[1] !== 4'd2 || wlog[2] !== 4'd3 || push_cnt !== 3 || pop_cnt !== 3) begin
            errors++;
            $display("FAIL reverse_ops: wdata %0d %0d %0d push %0d pop %0d, need 1 2 3 3 3",
                     wlog[0], wlog[1], wlog[2], push_cnt, pop_cnt);
        end
    endtask

    task automatic test_mid_reset();
        clear_mon();
        send_pattern(4'd5, 40'h0000012345, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.stk_push !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_push: stk_push %b, need 1", bus.stk_push);
        end
        #1 reset = 1'b0;
        #1 check_reset_outputs("midreset_values");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (valid_cnt !== 0) begin
            errors++;
            $display("FAIL midreset_no_valid: got %0d pulses, need 0", valid_cnt);
        end
        test_reverse(1'b1);
    endtask

    initial begin
        bus.data     = '0;
        bus.data_vld = 1'b0;
        force_full   = 1'b0;
        test_reset();
        test_identity();
        test_unreachable();
        test_bad_header();
        test_full();
        test_reverse(1'b0);
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
